// File: rtl/array_pkg.sv
// Shared definitions for the systolic-array feeder: array geometry, pipeline length
// and the sequencer state encoding.
package array_pkg;

   localparam int unsigned ARRAY_DIM = 4;
   localparam int unsigned ARRAY_LAT = 8;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StDrain
   } feeder_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO with occupancy count; head data reads as zero while empty.
module result_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CntFull = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             empty, full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntFull);
   assign do_pop  = pop_i && !empty;
   // A pop in the same cycle frees the slot a push at full needs.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (do_push && !do_pop) begin
         count_d = count_q + CntOne;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntOne;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o = !empty;
   assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/array_feeder.sv
// Sequencer between the stream datapath and the 4x4 weight-stationary array: skews
// activations in, de-skews column results out, and throttles input by FIFO credit.
module array_feeder
   import array_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ACCUMULATE = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   cfg_start_i,
   input  logic [ARRAY_DIM*ARRAY_DIM*WIDTH-1:0]   cfg_weights_i,
   output logic                                   cfg_busy_o,
   input  logic                                   s_valid_i,
   output logic                                   s_ready_o,
   input  logic [ARRAY_DIM*WIDTH-1:0]             s_data_i,
   output logic                                   m_valid_o,
   input  logic                                   m_ready_i,
   output logic [ARRAY_DIM*ACCUMULATE-1:0]        m_data_o,
   output logic                                   arr_load_o,
   output logic [ARRAY_DIM*ARRAY_DIM*WIDTH-1:0]   arr_weights_o,
   output logic [ARRAY_DIM*WIDTH-1:0]             arr_row_o,
   input  logic [ARRAY_DIM*ACCUMULATE-1:0]        arr_result_i
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CntOne    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW:0]   CreditLim = DEPTH[CW:0];

   feeder_state_t                          state_q, state_d;
   logic [ARRAY_DIM*ARRAY_DIM*WIDTH-1:0]   weights_q, weights_d;
   logic [CW-1:0]                          inflight_q, inflight_d;
   logic [ARRAY_LAT-1:0]                   tag_q;
   logic [CW-1:0]                          fifo_count;
   logic [ARRAY_DIM*ACCUMULATE-1:0]        push_data;
   logic                                   accept, push, pop;

   assign s_ready_o = (state_q == StRun) &&
                      (({1'b0, inflight_q} + {1'b0, fifo_count}) < CreditLim);
   assign accept    = s_valid_i && s_ready_o;
   assign push      = tag_q[ARRAY_LAT-1];
   assign pop       = m_valid_o && m_ready_i;

   always_comb begin
      inflight_d = inflight_q;
      if (accept && !push) begin
         inflight_d = inflight_q + CntOne;
      end else if (!accept && push) begin
         inflight_d = inflight_q - CntOne;
      end
   end

   always_comb begin
      state_d    = state_q;
      weights_d  = weights_q;
      arr_load_o = 1'b0;
      cfg_busy_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (cfg_start_i) begin
               weights_d = cfg_weights_i;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            arr_load_o = 1'b1;
            cfg_busy_o = 1'b1;
            state_d    = StRun;
         end
         StRun: begin
            // A vector accepted alongside cfg_start still belongs to the old weights.
            if (cfg_start_i) begin
               weights_d = cfg_weights_i;
               state_d   = (inflight_d == '0) ? StLoad : StDrain;
            end
         end
         StDrain: begin
            cfg_busy_o = 1'b1;
            if (inflight_q == '0) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         weights_q  <= '0;
         inflight_q <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         weights_q  <= weights_d;
         inflight_q <= inflight_d;
         tag_q      <= {tag_q[ARRAY_LAT-2:0], accept};
      end
   end

   assign arr_weights_o = weights_q;

   // Row r sees its element r cycles after the issue cycle; bubbles shift in zeros.
   for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_skew
      logic [WIDTH-1:0] line_q [r+1];
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s <= r; s++) line_q[s] <= '0;
         end else begin
            line_q[0] <= accept ? s_data_i[r*WIDTH +: WIDTH] : '0;
            for (int s = 1; s <= r; s++) line_q[s] <= line_q[s-1];
         end
      end
      assign arr_row_o[r*WIDTH +: WIDTH] = line_q[r];
   end

   // Column c is captured at tag stage 4+c and delayed so all columns meet at stage 7.
   for (genvar c = 0; c < ARRAY_DIM - 1; c++) begin : g_deskew
      localparam int Len = ARRAY_DIM - 1 - c;
      logic [ACCUMULATE-1:0] line_q [Len];
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < Len; s++) line_q[s] <= '0;
         end else begin
            line_q[0] <= tag_q[ARRAY_DIM+c] ? arr_result_i[c*ACCUMULATE +: ACCUMULATE] : '0;
            for (int s = 1; s < Len; s++) line_q[s] <= line_q[s-1];
         end
      end
      assign push_data[c*ACCUMULATE +: ACCUMULATE] = line_q[Len-1];
   end

   assign push_data[(ARRAY_DIM-1)*ACCUMULATE +: ACCUMULATE] =
      arr_result_i[(ARRAY_DIM-1)*ACCUMULATE +: ACCUMULATE];

   result_fifo #(
      .WIDTH (ARRAY_DIM*ACCUMULATE),
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (m_data_o),
      .valid_o (m_valid_o),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_array_feeder.sv
// Bench for array_feeder with a behavioural 4x4 weight-stationary array and a
// matrix-product scoreboard.
module tb_array_feeder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0;
   logic [127:0] cfg_weights = '0;
   logic         cfg_busy;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [127:0] m_data;
   logic         arr_load;
   logic [127:0] arr_weights;
   logic [31:0]  arr_row;
   logic [127:0] arr_result;

   always #5 clk = ~clk;

   array_feeder #(
      .WIDTH      (8),
      .ACCUMULATE (32),
      .DEPTH      (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .cfg_start_i   (cfg_start),
      .cfg_weights_i (cfg_weights),
      .cfg_busy_o    (cfg_busy),
      .s_valid_i     (s_valid),
      .s_ready_o     (s_ready),
      .s_data_i      (s_data),
      .m_valid_o     (m_valid),
      .m_ready_i     (m_ready),
      .m_data_o      (m_data),
      .arr_load_o    (arr_load),
      .arr_weights_o (arr_weights),
      .arr_row_o     (arr_row),
      .arr_result_i  (arr_result)
   );

   // Weight-stationary PE grid: activations move east, partial sums move south.
   for (genvar r = 0; r < 4; r++) begin : g_r
      for (genvar c = 0; c < 4; c++) begin : g_c
         logic [7:0]  w_q, a_q, a_in;
         logic [31:0] p_q, p_in;
         if (c == 0) begin : g_west
            assign a_in = arr_row[r*8 +: 8];
         end else begin : g_east
            assign a_in = g_r[r].g_c[c-1].a_q;
         end
         if (r == 0) begin : g_top
            assign p_in = '0;
         end else begin : g_south
            assign p_in = g_r[r-1].g_c[c].p_q;
         end
         always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               w_q <= '0;
               a_q <= '0;
               p_q <= '0;
            end else begin
               if (arr_load) w_q <= arr_weights[(r*4+c)*8 +: 8];
               a_q <= a_in;
               p_q <= p_in + 32'(a_in) * 32'(w_q);
            end
         end
         if (r == 3) begin : g_out
            assign arr_result[c*32 +: 32] = p_q;
         end
      end
   end

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           last_acc_cyc = 0;
   logic [127:0] model_w = '0;
   logic [127:0] exp_q [$];
   int           pop_cyc [$];
   logic [31:0]  acc_x [int];
   logic         prev_mv = 1'b0;
   logic         prev_mr = 1'b0;
   logic [127:0] prev_md = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // y[c] = sum over r of x[r] * W[r][c]
   function automatic logic [127:0] ref_model(input logic [31:0] x, input logic [127:0] w);
      logic [127:0] res;
      logic [31:0]  acc;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         acc = '0;
         for (int r = 0; r < 4; r++) acc += 32'(x[r*8 +: 8]) * 32'(w[(r*4+c)*8 +: 8]);
         res[c*32 +: 32] = acc;
      end
      return res;
   endfunction

   // Monitor: scoreboard pop, output hold, accept bookkeeping and row-skew check.
   always @(negedge clk) begin
      logic [31:0] vx;
      logic [7:0]  er;
      if (rst_n) begin
         if (prev_mv && !prev_mr) begin
            check("m_hold_valid", m_valid, 1);
            check("m_hold_data", m_data, prev_md);
         end
         if (m_valid && exp_q.size() == 0) begin
            check("spurious_m_valid", m_valid, 0);
         end else if (m_valid && m_ready) begin
            pop_cyc.push_back(cyc);
            check("result", m_data, exp_q.pop_front());
         end
         if (s_valid && s_ready) begin
            exp_q.push_back(ref_model(s_data, model_w));
            acc_x[cyc] = s_data;
            last_acc_cyc = cyc;
         end
         for (int r = 0; r < 4; r++) begin
            er = '0;
            if (acc_x.exists(cyc - 1 - r)) begin
               vx = acc_x[cyc - 1 - r];
               er = vx[r*8 +: 8];
            end
            check($sformatf("arr_row%0d", r), arr_row[r*8 +: 8], er);
         end
      end
      prev_mv = m_valid && rst_n;
      prev_mr = m_ready;
      prev_md = m_data;
   end

   task automatic do_cfg(input logic [127:0] w);
      int n = 0;
      while (cfg_busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      cfg_start = 1'b1;
      cfg_weights = w;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      model_w = w;
   endtask

   task automatic send(input logic [31:0] x);
      int   n = 0;
      logic ok = 1'b0;
      s_valid = 1'b1;
      s_data = x;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = s_ready;
         n++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_data = '0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      logic [127:0] w_id, w_two, w_a, w_b;
      logic         ok;
      int           n, acc_cnt, loads, load_cyc, early, a3, remaining, gap;

      // Reset state
      #23;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_arr_load", arr_load, 0);
      check("rst_arr_weights", arr_weights, 0);
      check("rst_arr_row", arr_row, 0);
      check("rst_cfg_busy", cfg_busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("idle_s_ready", s_ready, 0);
      check("idle_cfg_busy", cfg_busy, 0);

      // Identity weights, latency and one-cycle load
      w_id = '0;
      for (int r = 0; r < 4; r++) w_id[(r*4+r)*8 +: 8] = 8'd1;
      do_cfg(w_id);
      @(negedge clk);
      check("load_strobe", arr_load, 1);
      check("load_busy", cfg_busy, 1);
      check("load_weights", arr_weights, w_id);
      check("load_s_ready", s_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("run_arr_load", arr_load, 0);
      check("run_s_ready", s_ready, 1);
      check("run_cfg_busy", cfg_busy, 0);
      @(posedge clk); #1;
      send(32'h04030201);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_valid && n < 20);
      check("latency", cyc - last_acc_cyc, 9);
      check("identity_data", m_data, {32'd4, 32'd3, 32'd2, 32'd1});
      @(posedge clk); #1;
      wait_drain();

      // All weights 2, back-to-back vectors emerge on consecutive cycles
      w_two = {16{8'd2}};
      do_cfg(w_two);
      pop_cyc.delete();
      send(32'h01010101);
      send(32'h01000003);
      wait_drain();
      check("b2b_count", pop_cyc.size(), 2);
      if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], 1);

      // Credit limit with m_ready low
      for (int i = 0; i < 4; i++) w_a[i*32 +: 32] = $urandom;
      do_cfg(w_a);
      m_ready = 1'b0;
      acc_cnt = 0;
      s_valid = 1'b1;
      s_data = $urandom;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ok = s_ready;
         if (ok) acc_cnt++;
         @(posedge clk); #1;
         if (ok) s_data = $urandom;
      end
      s_valid = 1'b0;
      check("credit_accepts", acc_cnt, 8);
      check("credit_s_ready", s_ready, 0);
      pop_cyc.delete();
      m_ready = 1'b1;
      wait_drain();
      check("credit_returned", pop_cyc.size(), 8);

      // Weight swap with three vectors in flight
      for (int i = 0; i < 3; i++) send($urandom);
      a3 = last_acc_cyc;
      for (int i = 0; i < 4; i++) w_b[i*32 +: 32] = $urandom;
      do_cfg(w_b);
      loads = 0;
      load_cyc = -1;
      early = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (arr_load) begin
            loads++;
            load_cyc = cyc;
         end
         if (s_ready && loads == 0) early++;
      end
      @(posedge clk); #1;
      check("swap_loads", loads, 1);
      check("swap_early_ready", early, 0);
      check("swap_load_cycle", load_cyc - a3, 10);
      send($urandom);
      wait_drain();

      // Random gaps and random back-pressure
      remaining = 30;
      gap = 0;
      n = 0;
      s_data = $urandom;
      while (remaining > 0 && n < 600) begin
         s_valid = (gap == 0);
         m_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         ok = s_valid && s_ready;
         @(posedge clk); #1;
         if (ok) begin
            remaining--;
            gap = $urandom_range(0, 3);
            s_data = $urandom;
         end else if (gap > 0) begin
            gap--;
         end
         n++;
      end
      s_valid = 1'b0;
      s_data = '0;
      check("gaps_all_sent", remaining, 0);
      m_ready = 1'b1;
      wait_drain();

      // Reset mid-stream with buffered results
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send($urandom);
      repeat (12) begin @(posedge clk); #1; end
      check("buffered_m_valid", m_valid, 1);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      acc_x.delete();
      #1;
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_s_ready", s_ready, 0);
      check("mid_rst_arr_row", arr_row, 0);
      check("mid_rst_arr_load", arr_load, 0);
      check("mid_rst_cfg_busy", cfg_busy, 0);
      check("mid_rst_arr_weights", arr_weights, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("post_rst_s_ready", s_ready, 0);
      check("post_rst_m_valid", m_valid, 0);
      check("post_rst_cfg_busy", cfg_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit reached expected finish");
      $fatal(1);
   end

endmodule
